ecu_seq: RTL and testbench

- Instruction step sequencer for the ECU.
- Owns the instruction register, the operand bytes d1/d2 and the 3-bit microcode step index `is` that drive the microcode decoder block.
- Consumes the decoder's sequencing lines (ir_we, pc_lrc, pc_ini, pc_cub, trap, len) and closes the fetch/execute loop: the decoder issues control words on the falling edge, and ecu_seq updates state on the rising edge.

---
 rtl/ecu_seq.sv | 136 +++++++++++++
 tb/tb_ecu_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ecu_seq.sv
// Instruction step sequencer: owns the instruction register, the operand bytes and the
// microcode step index. Closes the fetch/execute loop with the microcode decoder.
module ecu_seq #(
  parameter int unsigned STEPS      = 8,
  parameter int unsigned IS_W       = 3,
  parameter int unsigned CNT_W      = 16,
  parameter logic [7:0]  RESET_INSN = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bus_in,
  input  logic             ir_we,
  input  logic             pc_lrc,
  input  logic             pc_ini,
  input  logic             pc_cub,
  input  logic             trap,
  input  logic [1:0]       len,
  input  logic             resume,
  output logic [7:0]       insn,
  output logic [7:0]       d1,
  output logic [7:0]       d2,
  output logic [IS_W-1:0]  is,
  output logic             halted,
  output logic             fault,
  output logic             ctl_err,
  output logic [CNT_W-1:0] icnt
);

  localparam logic [IS_W-1:0] IS_MAX = IS_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       fidx, fidx_nx;
  logic [7:0]       insn_nx, d1_nx, d2_nx;
  logic [IS_W-1:0]  is_nx;
  logic [CNT_W-1:0] icnt_nx;
  logic             ctl_err_nx;

  logic [1:0] eff_len;
  logic       over_len;
  logic       multi_pc;

  // A length of 0 is treated as a one-byte instruction; the opcode slot is always writable.
  assign eff_len  = (len == 2'd0) ? 2'd1 : len;
  assign over_len = ir_we && (fidx != 2'd0) && (fidx >= eff_len);
  assign multi_pc = (pc_lrc & pc_ini) | (pc_lrc & pc_cub) | (pc_ini & pc_cub);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      fidx    <= 2'd0;
      insn    <= RESET_INSN;
      d1      <= 8'h00;
      d2      <= 8'h00;
      is      <= '0;
      icnt    <= '0;
      ctl_err <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nx;
      fidx    <= fidx_nx;
      insn    <= insn_nx;
      d1      <= d1_nx;
      d2      <= d2_nx;
      is      <= is_nx;
      icnt    <= icnt_nx;
      ctl_err <= ctl_err_nx;
      halted  <= (state_nx == S_HALT);
      fault   <= (state_nx == S_FAULT);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nx   = state;
    fidx_nx    = fidx;
    insn_nx    = insn;
    d1_nx      = d1;
    d2_nx      = d2;
    is_nx      = is;
    icnt_nx    = icnt;
    ctl_err_nx = ctl_err;

    case (state)
      S_RUN: begin
        if (trap) begin
          state_nx = S_HALT;
        end else begin
          if (multi_pc || over_len) ctl_err_nx = 1'b1;

          // Capture uses the byte slot addressed before any end-of-instruction reset.
          if (ir_we) begin
            if (!over_len) begin
              case (fidx)
                2'd0:    insn_nx = bus_in;
                2'd1:    d1_nx   = bus_in;
                default: d2_nx   = bus_in;
              endcase
            end
            if (fidx != 2'd2) fidx_nx = fidx + 2'd1;
          end

          if (pc_lrc || pc_ini) begin
            is_nx   = '0;
            fidx_nx = 2'd0;
            icnt_nx = icnt + CNT_W'(1);
          end else if (pc_cub) begin
            if (is == IS_MAX) state_nx = S_FAULT;
            else              is_nx    = is + IS_W'(1);
          end
        end
      end

      S_HALT: begin
        // Re-run the trapped opcode from step 0 with its bytes intact.
        if (resume) begin
          state_nx = S_RUN;
          is_nx    = '0;
          fidx_nx  = 2'd0;
        end
      end

      default: begin
        state_nx = S_FAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_ecu_seq.sv
// Directed bench for ecu_seq: vector table plus hand sequences for async reset and counter wrap.
module tb_ecu_seq;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  logic       ir_we, pc_lrc, pc_ini, pc_cub, trap, resume;
  logic [1:0] len;

  logic [7:0]  insn, d1, d2;
  logic [2:0]  is;
  logic        halted, fault, ctl_err;
  logic [15:0] icnt;

  logic [7:0] insn4, d14, d24;
  logic [2:0] is4;
  logic       halted4, fault4, ctl_err4;
  logic [3:0] icnt4;

  int errors;
  int checks;

  ecu_seq dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .ir_we(ir_we), .pc_lrc(pc_lrc),
    .pc_ini(pc_ini), .pc_cub(pc_cub), .trap(trap), .len(len), .resume(resume),
    .insn(insn), .d1(d1), .d2(d2), .is(is), .halted(halted), .fault(fault),
    .ctl_err(ctl_err), .icnt(icnt)
  );

  ecu_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus_in(bus_in), .ir_we(ir_we), .pc_lrc(pc_lrc),
    .pc_ini(pc_ini), .pc_cub(pc_cub), .trap(trap), .len(len), .resume(resume),
    .insn(insn4), .d1(d14), .d2(d24), .is(is4), .halted(halted4), .fault(fault4),
    .ctl_err(ctl_err4), .icnt(icnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [7:0]  bus;
    logic        we, lrc, ini, cub, trap;
    logic [1:0]  len;
    logic        resume;
    logic [7:0]  insn, d1, d2;
    logic [2:0]  is;
    logic        halted, fault, err;
    logic [15:0] icnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic [7:0] b, input logic we, input logic lrc, input logic ini,
    input logic cub, input logic tr, input logic [1:0] ln, input logic rs,
    input logic [7:0] e_insn, input logic [7:0] e_d1, input logic [7:0] e_d2,
    input logic [2:0] e_is, input logic e_h, input logic e_f, input logic e_err,
    input logic [15:0] e_icnt);
    vec_t v;
    v.rst = r; v.bus = b; v.we = we; v.lrc = lrc; v.ini = ini; v.cub = cub;
    v.trap = tr; v.len = ln; v.resume = rs;
    v.insn = e_insn; v.d1 = e_d1; v.d2 = e_d2; v.is = e_is;
    v.halted = e_h; v.fault = e_f; v.err = e_err; v.icnt = e_icnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] b, input logic we, input logic lrc,
                       input logic ini, input logic cub, input logic tr, input logic [1:0] ln,
                       input logic rs);
    @(negedge clk);
    rst = r; bus_in = b; ir_we = we; pc_lrc = lrc; pc_ini = ini; pc_cub = cub;
    trap = tr; len = ln; resume = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; bus_in = 8'h00; ir_we = 1'b0; pc_lrc = 1'b0; pc_ini = 1'b0;
    pc_cub = 1'b0; trap = 1'b0; len = 2'd0; resume = 1'b0;

    //           rst bus   we lrc ini cub trp len rs   insn  d1     d2     is  h  f  e  icnt
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h12, 1, 0, 0, 0, 0, 2'd0, 0, 8'h12, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'hAB, 1, 0, 0, 1, 0, 2'd2, 0, 8'h12, 8'hAB, 8'h00, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 2'd2, 0, 8'h12, 8'hAB, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h34, 1, 0, 0, 0, 0, 2'd3, 0, 8'h34, 8'hAB, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h56, 1, 0, 0, 0, 0, 2'd3, 0, 8'h34, 8'h56, 8'h00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h78, 1, 0, 0, 1, 0, 2'd3, 0, 8'h34, 8'h56, 8'h78, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h99, 1, 0, 0, 0, 0, 2'd3, 0, 8'h34, 8'h56, 8'h99, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h11, 1, 1, 0, 0, 0, 2'd3, 0, 8'h34, 8'h56, 8'h11, 0, 0, 0, 0, 2));
    for (int i = 1; i <= 3; i++)
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 2'd3, 0, 8'h34, 8'h56, 8'h11, 3'(i), 0, 0, 0, 2));
    // trap with a same-cycle step: step is ignored
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 2'd3, 0, 8'h34, 8'h56, 8'h11, 3, 1, 0, 0, 2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 2'd3, 0, 8'h34, 8'h56, 8'h11, 3, 1, 0, 0, 2));
    vecs.push_back(mk(0, 8'hFF, 1, 0, 0, 0, 0, 2'd1, 0, 8'h34, 8'h56, 8'h11, 3, 1, 0, 0, 2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 2'd3, 0, 8'h34, 8'h56, 8'h11, 3, 1, 0, 0, 2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 2'd3, 1, 8'h34, 8'h56, 8'h11, 0, 0, 0, 0, 2));
    // over-length operand write
    vecs.push_back(mk(0, 8'hA1, 1, 0, 0, 0, 0, 2'd1, 0, 8'hA1, 8'h56, 8'h11, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 8'h55, 1, 0, 0, 0, 0, 2'd1, 0, 8'hA1, 8'h56, 8'h11, 0, 0, 0, 1, 2));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 2'd0, 1, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 1));
    // step overflow into FAULT
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h42, 1, 0, 0, 0, 0, 2'd1, 0, 8'h42, 8'h00, 8'h00, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 7; i++)
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 2'd1, 0, 8'h42, 8'h00, 8'h00, 3'(i), 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 2'd1, 0, 8'h42, 8'h00, 8'h00, 7, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 2'd1, 0, 8'h42, 8'h00, 8'h00, 7, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 2'd1, 1, 8'h42, 8'h00, 8'h00, 7, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h77, 1, 0, 0, 0, 0, 2'd1, 0, 8'h42, 8'h00, 8'h00, 7, 0, 1, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      vec_t v;
      string tag;
      v = vecs[k];
      drive(v.rst, v.bus, v.we, v.lrc, v.ini, v.cub, v.trap, v.len, v.resume);
      tag = $sformatf("vec%0d", k);
      check({tag, ".insn"},    32'(insn),    32'(v.insn));
      check({tag, ".d1"},      32'(d1),      32'(v.d1));
      check({tag, ".d2"},      32'(d2),      32'(v.d2));
      check({tag, ".is"},      32'(is),      32'(v.is));
      check({tag, ".halted"},  32'(halted),  32'(v.halted));
      check({tag, ".fault"},   32'(fault),   32'(v.fault));
      check({tag, ".ctl_err"}, 32'(ctl_err), 32'(v.err));
      check({tag, ".icnt"},    32'(icnt),    32'(v.icnt));
    end

    // Async reset mid-instruction: d2=C3, is=5, then rst between edges.
    drive(0, 8'h01, 1, 0, 0, 0, 0, 2'd3, 0);
    drive(0, 8'h02, 1, 0, 0, 0, 0, 2'd3, 0);
    drive(0, 8'hC3, 1, 0, 0, 0, 0, 2'd3, 0);
    for (int i = 0; i < 5; i++) drive(0, 8'h00, 0, 0, 0, 1, 0, 2'd3, 0);
    check("pre_rst.is", 32'(is), 32'd5);
    check("pre_rst.d2", 32'(d2), 32'hC3);
    check("pre_rst.insn", 32'(insn), 32'h01);
    pc_cub = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.insn", 32'(insn), 32'h00);
    check("async_rst.is",   32'(is),   32'd0);
    check("async_rst.d2",   32'(d2),   32'h00);
    check("async_rst.d1",   32'(d1),   32'h00);
    drive(0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 0);

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 15; i++) drive(0, 8'h00, 0, 0, 1, 0, 0, 2'd0, 0);
    check("wrap.pre_icnt4", 32'(icnt4), 32'd15);
    drive(0, 8'h00, 0, 0, 1, 0, 0, 2'd0, 0);
    check("wrap.icnt4",    32'(icnt4),    32'd0);
    check("wrap.ctl_err4", 32'(ctl_err4), 32'd0);
    check("wrap.fault4",   32'(fault4),   32'd0);
    check("wrap.icnt16",   32'(icnt),     32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
